// File: rtl/div4_pkg.sv
// ============================================================================
//  Module   : div4_pkg
//  Purpose  : Shared types and constants for the 4-bit restoring divider.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package div4_pkg;

   localparam int DIV4_W    = 4;
   localparam int DIV4_ITER = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div4_state_t;

   // True when the iteration counter points at the final subtract step.
   function automatic logic div4_last_iter(input logic [1:0] cnt);
      return cnt == 2'(DIV4_ITER - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/div4_restoring_addsub.sv
// ============================================================================
//  Module   : AddSub4
//  Purpose  : 4-bit ripple adder/subtractor; sel=1 computes a - b, cout=1
//             meaning no borrow.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module AddSub4
   import div4_pkg::*;
(
   input  logic [DIV4_W-1:0] a,
   input  logic [DIV4_W-1:0] b,
   input  logic              sel,
   output logic              cout,
   output logic [DIV4_W-1:0] sum
);

   logic [DIV4_W-1:0] b_x;
   logic [DIV4_W:0]   carry;

   // Subtraction is a + ~b + 1: invert b and inject sel as the carry-in.
   assign b_x      = b ^ {DIV4_W{sel}};
   assign carry[0] = sel;

   generate
      for (genvar i = 0; i < DIV4_W; i++) begin : g_fa
         assign sum[i]     = a[i] ^ b_x[i] ^ carry[i];
         assign carry[i+1] = (a[i] & b_x[i]) | (carry[i] & (a[i] ^ b_x[i]));
      end
   endgenerate

   assign cout = carry[DIV4_W];

endmodule

`default_nettype wire

// File: rtl/div4_restoring.sv
// ============================================================================
//  Module   : div4_restoring
//  Purpose  : Sequential 4-bit unsigned restoring divider, one quotient bit
//             per cycle through a shared AddSub4. Optional macro
//             DIV4_DBZ_ERR_EN enables the divide-by-zero shortcut and err flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div4_restoring
   import div4_pkg::*;
#(
   parameter int ITER = DIV4_ITER
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIV4_W-1:0] dividend,
   input  logic [DIV4_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [DIV4_W-1:0] quotient,
   output logic [DIV4_W-1:0] remainder,
   output logic              err
);

   div4_state_t       state_q, state_d;
   logic [DIV4_W-1:0] rem_q, rem_d;
   logic [DIV4_W-1:0] quo_q, quo_d;
   logic [DIV4_W-1:0] dsr_q, dsr_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [DIV4_W-1:0] quotient_q, quotient_d;
   logic [DIV4_W-1:0] remainder_q, remainder_d;

   logic              hi;
   logic [DIV4_W-1:0] low4;
   logic [DIV4_W-1:0] as_sum;
   logic              as_cout;
   logic              accept;
   logic [DIV4_W-1:0] rem_nxt;
   logic [DIV4_W-1:0] quo_nxt;
   logic              can_start;

   // The shifted-out remainder MSB forces acceptance: the 5-bit value then
   // exceeds any 4-bit divisor, and the 4-bit difference is still exact.
   assign hi      = rem_q[DIV4_W-1];
   assign low4    = {rem_q[DIV4_W-2:0], quo_q[DIV4_W-1]};
   assign accept  = hi | as_cout;
   assign rem_nxt = accept ? as_sum : low4;
   assign quo_nxt = {quo_q[DIV4_W-2:0], accept};

   AddSub4 u_addsub (
      .a    (low4),
      .b    (dsr_q),
      .sel  (1'b1),
      .cout (as_cout),
      .sum  (as_sum)
   );

   assign can_start = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef DIV4_DBZ_ERR_EN
   logic err_q, err_d;
   logic dbz_q, dbz_d;

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dsr_d       = dsr_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      err_d       = err_q;
      dbz_d       = dbz_q;
      case (state_q)
         IDLE, DONE: begin
            if (can_start) begin
               rem_d   = '0;
               quo_d   = dividend;
               dsr_d   = divisor;
               cnt_d   = '0;
               err_d   = 1'b0;
               dbz_d   = (divisor == '0);
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (dbz_q) begin
               // quo_q still holds the untouched dividend here.
               quotient_d  = '1;
               remainder_d = quo_q;
               err_d       = 1'b1;
               dbz_d       = 1'b0;
               state_d     = DONE;
            end else begin
               rem_d       = rem_nxt;
               quo_d       = quo_nxt;
               cnt_d       = cnt_q + 2'd1;
               quotient_d  = quo_nxt;
               remainder_d = rem_nxt;
               if (cnt_q == 2'(ITER - 1)) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
         dbz_q <= 1'b0;
      end else begin
         err_q <= err_d;
         dbz_q <= dbz_d;
      end
   end

   assign busy = (state_q == RUN) && !dbz_q;
   assign err  = err_q;
`else
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dsr_d       = dsr_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      case (state_q)
         IDLE, DONE: begin
            if (can_start) begin
               rem_d   = '0;
               quo_d   = dividend;
               dsr_d   = divisor;
               cnt_d   = '0;
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            rem_d       = rem_nxt;
            quo_d       = quo_nxt;
            cnt_d       = cnt_q + 2'd1;
            quotient_d  = quo_nxt;
            remainder_d = rem_nxt;
            if (div4_last_iter(cnt_q)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == RUN);
   assign err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         dsr_q       <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dsr_q       <= dsr_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign done      = (state_q == DONE);
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

`default_nettype wire

// File: tb/tb_div4_restoring.sv
// ============================================================================
//  Module   : tb_div4_restoring
//  Purpose  : Scoreboard bench for div4_restoring against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div4_restoring;

`ifdef DIV4_DBZ_ERR_EN
   localparam bit DBZ = 1'b1;
`else
   localparam bit DBZ = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] dividend = '0;
   logic [3:0] divisor = '0;
   logic       busy, done, err;
   logic [3:0] quotient, remainder;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int q;
      int r;
      int e;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   div4_restoring dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .err       (err)
   );

   task automatic check(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   function automatic exp_t model(input int a, input int b);
      exp_t x;
      if (b == 0) begin
         x.q = 15;
         x.r = a;
         x.e = DBZ ? 1 : 0;
      end else begin
         x.q = a / b;
         x.r = a % b;
         x.e = 0;
      end
      return x;
   endfunction

   function automatic int latency(input int b);
      return (DBZ && b == 0) ? 1 : 4;
   endfunction

   // Monitor: every done pulse consumes exactly one expected result.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               x = sb.pop_front();
               check("quotient", int'(quotient), x.q);
               check("remainder", int'(remainder), x.r);
               check("err", int'(err), x.e);
            end
         end
      end
   end

   // Present operands so that the next rising edge (edge k) captures them.
   task automatic issue(input int a, input int b, output int busy_cnt);
      @(negedge clk);
      start    = 1'b1;
      dividend = 4'(a);
      divisor  = 4'(b);
      @(posedge clk);
      sb.push_back(model(a, b));
      #1;
      start    = 1'b0;
      busy_cnt = int'(busy);
   endtask

   task automatic wait_done(input string name, input int b, input int busy_cnt_in);
      int busy_cnt;
      int lat;
      busy_cnt = busy_cnt_in;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = c;
            break;
         end
         busy_cnt += int'(busy);
      end
      check({name, "_latency"}, lat, latency(b));
      check({name, "_busy_cycles"}, busy_cnt, (latency(b) == 4) ? 4 : 0);
   endtask

   task automatic run_div(input string name, input int a, input int b);
      int bc;
      issue(a, b, bc);
      wait_done(name, b, bc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc;
      int nd;
      int seen;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_quotient", int'(quotient), 0);
      check("reset_remainder", int'(remainder), 0);
      check("reset_err", int'(err), 0);

      run_div("13div3", 13, 3);
      run_div("15div1", 15, 1);
      run_div("2div5", 2, 5);
      run_div("9div9", 9, 9);

      // Extra start pulses at edges k+2 and k+3 must be ignored.
      issue(12, 7, bc);
      @(posedge clk); #1;
      start = 1'b1; dividend = 4'd5; divisor = 4'd1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("12div7_done_at_k4", int'(done), 1);
      repeat (3) @(posedge clk);
      #1;
      check("hold_quotient", int'(quotient), 1);
      check("hold_remainder", int'(remainder), 5);
      check("hold_idle_done", int'(done), 0);

      run_div("7div0", 7, 0);

      // Reset at edge k+2 aborts; no done may follow.
      @(negedge clk);
      start = 1'b1; dividend = 4'd11; divisor = 4'd2;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_quotient", int'(quotient), 0);
      check("abort_remainder", int'(remainder), 0);
      check("abort_err", int'(err), 0);
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         seen += int'(done);
      end
      check("abort_no_done", seen, 0);
      run_div("11div2", 11, 2);

      // start held high: accepts at edges k, k+5, k+10.
      @(negedge clk);
      start = 1'b1; dividend = 4'd14; divisor = 4'd4;
      repeat (3) sb.push_back(model(14, 4));
      nd = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (done) begin
            check("b2b_done_spacing", c, 4 + 5 * nd);
            nd++;
         end
         if (c == 10) start = 1'b0;
      end
      check("b2b_done_count", nd, 3);

      for (int i = 0; i < 24; i++) begin
         run_div("random", int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
